// File: rtl/nn_argmax_pkg.sv
// nn_argmax_pkg: shared types and default sizes for the argmax stream block.
// Optional feature macro: ARGMAX_SCORE_EN (adds m_score output).
package nn_argmax_pkg;

    localparam int unsigned NUM_CLASSES_DEF = 10;
    localparam int unsigned DATA_W_DEF      = 32;
    localparam int unsigned IDX_W_DEF       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/nn_argmax_stream_if.sv
// nn_argmax_stream_if: score stream input and class result handshake.
// Optional feature macro: ARGMAX_SCORE_EN (adds m_score to the bundle).
// slave = argmax block view; master = score producer / result consumer view.
interface nn_argmax_stream_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
) ();
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic              s_tlast;
    logic [IDX_W-1:0]  m_class;
    logic              m_valid;
    logic              m_ready;
`ifdef ARGMAX_SCORE_EN
    logic [DATA_W-1:0] m_score;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_ready,
        output s_tready, m_class, m_valid, m_score
    );
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_ready,
        input  s_tready, m_class, m_valid, m_score
    );
`else
    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_ready,
        output s_tready, m_class, m_valid
    );
    modport master (
        output s_tdata, s_tvalid, s_tlast, m_ready,
        input  s_tready, m_class, m_valid
    );
`endif
endinterface

// File: rtl/nn_argmax_stream_max_cmp.sv
// nn_max_cmp: combinational signed compare-and-select for one score beat.
// The first beat of a frame always wins; later beats win only on strict
// greater-than, so ties keep the lowest index.
module nn_max_cmp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                     i_first,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]         i_data_idx,
    input  logic signed [DATA_W-1:0] i_max,
    input  logic [IDX_W-1:0]         i_max_idx,
    output logic signed [DATA_W-1:0] o_max,
    output logic [IDX_W-1:0]         o_max_idx
);

    // Select the incoming beat when it is the first or strictly larger.
    always_comb begin
        o_max     = i_max;
        o_max_idx = i_max_idx;
        if (i_first || (i_data > i_max)) begin
            o_max     = i_data;
            o_max_idx = i_data_idx;
        end
    end

endmodule

// File: rtl/nn_argmax_stream.sv
// nn_argmax_stream: picks the index of the largest signed score in a frame
// of NUM_CLASSES beats and holds it behind a valid/ready handshake.
// Optional feature macro: ARGMAX_SCORE_EN (exposes the winning score).
module nn_argmax_stream
    import nn_argmax_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                start,
    nn_argmax_stream_if.slave   bus,
    output logic                busy,
    output logic                err_len
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                     r_state;
    logic [IDX_W-1:0]           r_count;
    logic signed [DATA_W-1:0]   r_max;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_tready;
    logic                       r_mvalid;
    logic                       r_busy;
    logic                       r_err;

    logic                       w_accept;
    logic signed [DATA_W-1:0]   w_new_max;
    logic [IDX_W-1:0]           w_new_idx;

    assign w_accept = bus.s_tvalid && r_tready;

    nn_max_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .i_first    (r_count == '0),
        .i_data     (bus.s_tdata),
        .i_data_idx (r_count),
        .i_max      (r_max),
        .i_max_idx  (r_idx),
        .o_max      (w_new_max),
        .o_max_idx  (w_new_idx)
    );

    // Frame FSM with beat counter, running max and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_max    <= '0;
            r_idx    <= '0;
            r_tready <= 1'b0;
            r_mvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= ACCUM;
                        r_count  <= '0;
                        r_max    <= '0;
                        r_err    <= 1'b0;
                        r_tready <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_max   <= w_new_max;
                        r_idx   <= w_new_idx;
                        r_count <= r_count + 1'b1;
                        // Full-length end wins over tlast on the same beat.
                        if (r_count == LAST_IDX) begin
                            r_state  <= HOLD;
                            r_err    <= 1'b0;
                            r_tready <= 1'b0;
                            r_mvalid <= 1'b1;
                        end else if (bus.s_tlast) begin
                            r_state  <= HOLD;
                            r_err    <= 1'b1;
                            r_tready <= 1'b0;
                            r_mvalid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.m_ready) begin
                        r_state  <= IDLE;
                        r_mvalid <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tready <= 1'b0;
                    r_mvalid <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_tready = r_tready;
    assign bus.m_valid  = r_mvalid;
    assign bus.m_class  = r_idx;
    assign busy         = r_busy;
    assign err_len      = r_err;
`ifdef ARGMAX_SCORE_EN
    assign bus.m_score  = r_max;
`endif

endmodule
